// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial-receive bundle between a line/tick source and uart_rx.
//
// Signals:
//   s_tick        baud oversampling strobe (16 per bit), one clk wide
//   rx            serial line, idle high, LSB-first frames
//   rx_dout       last received data word (DBIT bits)
//   rx_done_tick  one-clk pulse when a frame completes
//   frame_err     stop bit was sampled low on the last completed frame
//   parity_err    parity mismatch on the last completed frame
//
// Modports:
//   master  drives s_tick/rx, observes the receive results
//   slave   the receiver: consumes s_tick/rx, drives the results
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output s_tick,
    output rx,
    input  rx_dout,
    input  rx_done_tick,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output rx_dout,
    output rx_done_tick,
    output frame_err,
    output parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (16 s_tick per bit period).
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    uart_rx_if.slave: s_tick, rx in; rx_dout, rx_done_tick,
//          frame_err, parity_err out
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  s_tick periods in the stop bit (16/24/32 = 1/1.5/2 stop bits)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, one even-parity bit follows the data
//                      bits and parity_err reports mismatches; otherwise
//                      frames go DATA -> STOP and parity_err is held at 0.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic    clk,
  input  logic    reset,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t          r_state;
  logic [4:0]      r_s;
  logic [2:0]      r_n;
  logic [DBIT-1:0] r_b;
  logic            r_sync1;
  logic            r_sync2;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
`ifdef UART_RX_PARITY_EN
  logic            r_perr;
  logic            r_par_pend;
`endif

  logic w_rx;

  // Only the second synchronizer stage is ever used for decisions.
  assign w_rx = r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_s        <= '0;
      r_n        <= '0;
      r_b        <= '0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_dout     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr     <= 1'b0;
      r_par_pend <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;

      case (r_state)
        IDLE: begin
          // Not gated by s_tick so an edge right after completion is caught.
          if (!w_rx) begin
            r_state <= START;
            r_s     <= '0;
          end
        end

        START: begin
          if (bus.s_tick) begin
            if (r_s == 5'd7) begin
              if (!w_rx) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                // Start bit not low at mid-bit: treat as a glitch.
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end

        DATA: begin
          if (bus.s_tick) begin
            if (r_s == 5'd15) begin
              r_s <= '0;
              r_b <= {w_rx, r_b[DBIT-1:1]};
              if (r_n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.s_tick) begin
            if (r_s == 5'd15) begin
              r_s        <= '0;
              // Even parity: data ones plus the parity bit must be even.
              r_par_pend <= (^r_b) ^ w_rx;
              r_state    <= STOP;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`endif

        STOP: begin
          if (bus.s_tick) begin
            if (r_s == 5'(SB_TICK - 1)) begin
              r_dout  <= r_b;
              r_ferr  <= ~w_rx;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_par_pend;
`endif
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_dout      = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = r_perr;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, number of s_tick periods in the stop bit (16/24/32 = 1/1.5/2 stop bits).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  baud oversampling strobe, one clk wide, 16 per bit period.
REQ-006 rx  input  1  asynchronous serial line, idle high, LSB-first frames.
REQ-007 rx_dout  output  DBIT  last received data word.
REQ-008 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 frame_err  output  1  stop bit sampled low on the last completed frame.
REQ-010 parity_err  output  1  parity mismatch on the last completed frame.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-013 Tick counter s is 5 bits wide; bit counter n is 3 bits wide; shift register b is DBIT bits wide.
REQ-014 Counters and shift register SHALL hold when s_tick is low.
REQ-015 IDLE: synchronized rx low -> START, s=0.
REQ-016 START: on s_tick with s==7 (mid-bit), rx low -> DATA with s=0, n=0; rx high -> IDLE (glitch reject, no output change); otherwise s++.
REQ-017 DATA: on s_tick with s==15: s=0, b={rx, b[DBIT-1:1]}; n==DBIT-1 -> PARITY (macro) or STOP, else n++; otherwise s++.
REQ-018 PARITY: on s_tick with s==15: s=0, latch pending parity error = (XOR of b) XOR rx (even parity) -> STOP; otherwise s++.
REQ-019 STOP: on s_tick with s==SB_TICK-1: rx_dout<=b, frame_err<=~rx, parity_err<=pending value, rx_done_tick<=1, -> IDLE; otherwise s++.
REQ-020 rx_done_tick SHALL be registered, high exactly one clk, in the cycle after the s_tick that ends STOP.
REQ-021 rx_dout, frame_err and parity_err SHALL be updated only with rx_done_tick and hold until the next completion.
REQ-022 A frame with a framing error SHALL still deliver rx_dout and rx_done_tick.
REQ-023 A falling edge in IDLE on the clk after rx_done_tick SHALL be accepted (back-to-back frames, no dead cycle).
REQ-024 Illegal state encodings SHALL return to IDLE on the next clk.

Reset
REQ-025 On reset: state=IDLE, s=0, n=0, b=0, rx_dout=0, rx_done_tick=0, frame_err=0, parity_err=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick and no change to error flags beyond clearing them.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state compiled in; one even-parity bit expected after the data bits; parity_err driven per REQ-018/019.
REQ-028 Macro undefined: no PARITY state; DATA -> STOP directly; parity_err tied to 0; port list unchanged.

Verification
REQ-029 s_tick every 4 clks, frame 0x55 with valid stop bit -> rx_dout=0x55, one rx_done_tick, frame_err=0.
REQ-030 rx low for 5 s_ticks then high -> FSM returns to IDLE, no rx_done_tick, rx_dout unchanged.
REQ-031 Frame 0x3C with stop bit low -> rx_dout=0x3C, rx_done_tick pulses, frame_err=1; next clean frame 0x3C clears frame_err.
REQ-032 Reset asserted during data bit 4 of a frame -> IDLE, no rx_done_tick; following frame 0xA3 -> rx_dout=0xA3.
REQ-033 Frames 0x00 then 0xFF back-to-back -> two rx_done_tick pulses, rx_dout 0x00 then 0xFF.
REQ-034 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0; without the macro parity_err=0 always.
